// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer.
package bit_serializer_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word pending slot, shift stall and
// gapless word-to-word handoff.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             a,
    output logic             a_valid,
    output logic             a_last
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [WIDTH-1:0] pr, pr_n;
    logic             pr_full, pr_full_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             a_n, a_valid_n, a_last_n;
    logic             accept;
    logic             bypass;
    logic [WIDTH-1:0] sr_shift;

    // State and output registers; outputs are precomputed from next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sr       <= '0;
            pr       <= '0;
            pr_full  <= 1'b0;
            cnt      <= '0;
            a        <= 1'b0;
            a_valid  <= 1'b0;
            a_last   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            pr       <= pr_n;
            pr_full  <= pr_full_n;
            cnt      <= cnt_n;
            a        <= a_n;
            a_valid  <= a_valid_n;
            a_last   <= a_last_n;
            in_ready <= ~pr_full_n;
        end
    end

    // Next-state, slot management and next output values.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        pr_n      = pr;
        pr_full_n = pr_full;
        cnt_n     = cnt;
        accept    = in_valid & in_ready;
        bypass    = 1'b0;
        sr_shift  = MSB_FIRST ? (sr << 1) : (sr >> 1);

        case (state)
            IDLE: begin
                if (accept) begin
                    sr_n    = in_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (en && (cnt == CNT_LAST)) begin
                    cnt_n = '0;
                    if (pr_full) begin
                        sr_n      = pr;
                        pr_full_n = 1'b0;
                    end else if (accept) begin
                        sr_n   = in_data;
                        bypass = 1'b1;
                    end else begin
                        sr_n    = '0;
                        state_n = IDLE;
                    end
                end else if (en) begin
                    sr_n  = sr_shift;
                    cnt_n = cnt + CW'(1);
                end
                // A word accepted while shifting parks in PR unless it bypassed.
                if (accept && !bypass) begin
                    pr_n      = in_data;
                    pr_full_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        a_valid_n = (state_n == SHIFT);
        a_n       = a_valid_n & (MSB_FIRST ? sr_n[WIDTH-1] : sr_n[0]);
        a_last_n  = a_valid_n & (cnt_n == CNT_LAST);
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer against a word-queue model.
module tb_bit_serializer;

    localparam int N = 3;

    logic        clk;
    logic        reset;
    logic        en;
    logic [2:0]  vld;
    logic [31:0] dat [N];
    logic [2:0]  rdy;
    logic [2:0]  a;
    logic [2:0]  av;
    logic [2:0]  al;

    int wd   [N] = '{8, 8, 10};
    bit msbf [N] = '{1'b1, 1'b0, 1'b1};

    // Model: up to two words held per instance, head word and its bit index.
    logic [31:0] mword [N][2];
    int          mcnt  [N];
    int          midx  [N];
    bit          mrdy  [N];
    bit          acc   [N];

    int tests;
    int fails;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_data(dat[0][7:0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .en(en), .a(a[0]), .a_valid(av[0]), .a_last(al[0])
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_data(dat[1][7:0]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .en(en), .a(a[1]), .a_valid(av[1]), .a_last(al[1])
    );

    bit_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) u_w10 (
        .clk(clk), .reset(reset), .in_data(dat[2][9:0]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .en(en), .a(a[2]), .a_valid(av[2]), .a_last(al[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input int i);
        logic [31:0] w;
        w = mword[i][0];
        if (mcnt[i] == 0) return 1'b0;
        return msbf[i] ? w[wd[i]-1-midx[i]] : w[midx[i]];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mcnt[i] = 0;
            midx[i] = 0;
            mrdy[i] = 1'b0;
            acc[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            acc[i] = vld[i] && mrdy[i];
            if (mcnt[i] > 0 && en) begin
                if (midx[i] == wd[i] - 1) begin
                    mword[i][0] = mword[i][1];
                    mcnt[i]--;
                    midx[i] = 0;
                end else begin
                    midx[i]++;
                end
            end
            if (acc[i]) begin
                if (mcnt[i] == 0) midx[i] = 0;
                mword[i][mcnt[i]] = dat[i];
                mcnt[i]++;
            end
            mrdy[i] = (mcnt[i] < 2);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(mrdy[i]));
            check($sformatf("a_valid%0d", i), 32'(av[i]), 32'(mcnt[i] > 0));
            check($sformatf("a_last%0d", i), 32'(al[i]), 32'(mcnt[i] > 0 && midx[i] == wd[i] - 1));
            check($sformatf("a%0d", i), 32'(a[i]), 32'(exp_bit(i)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        for (int i = 0; i < N; i++) if (acc[i]) vld[i] = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Called at posedge+1; asserts reset off-edge for 12 time units.
    task automatic do_reset();
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check_all();
        #11;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] cap;
        int          nb;
        int          lastat;
        bit          sent;
        bit          saw_low;
        bit          found;

        tests = 0;
        fails = 0;
        reset = 1'b0;
        en    = 1'b0;
        vld   = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        model_clear();
        #1;
        check_all();
        #7;
        reset = 1'b1;
        step();
        check("ready_after_release", 32'(rdy[0]), 32'd1);

        // Single word 0x37, MSB first.
        en = 1'b1;
        dat[0] = 32'h37; vld[0] = 1'b1;
        cap = '0; nb = 0; lastat = 0;
        repeat (12) begin
            step();
            if (av[0]) begin
                cap = {cap[14:0], a[0]};
                nb++;
                if (al[0]) lastat = nb;
            end
        end
        check("single_seq", 32'(cap[7:0]), 32'h37);
        check("single_nbits", 32'(nb), 32'd8);
        check("single_lastpos", 32'(lastat), 32'd8);

        // Back-to-back 0x37 then 0xA5.
        dat[0] = 32'h37; vld[0] = 1'b1;
        sent = 1'b0; saw_low = 1'b0; cap = '0; nb = 0;
        repeat (22) begin
            step();
            if (!sent && acc[0]) begin
                dat[0] = 32'hA5; vld[0] = 1'b1; sent = 1'b1;
            end
            if (av[0]) begin
                cap = {cap[14:0], a[0]};
                nb++;
            end
            if (av[0] && !rdy[0]) saw_low = 1'b1;
        end
        check("b2b_seq", 32'(cap), 32'h37A5);
        check("b2b_nbits", 32'(nb), 32'd16);
        check("b2b_ready_drop", 32'(saw_low), 32'd1);

        // Stall after the 4th bit of 0x37.
        dat[0] = 32'h37; vld[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (av[0] && midx[0] == 3) found = 1'b1;
        end
        check("stall_reach", 32'(found), 32'd1);
        en = 1'b0;
        repeat (3) begin
            step();
            check("stall_a", 32'(a[0]), 32'd1);
            check("stall_valid", 32'(av[0]), 32'd1);
        end
        en = 1'b1;
        cap = '0;
        repeat (4) begin
            step();
            cap = {cap[14:0], a[0]};
        end
        check("stall_rest", 32'(cap[3:0]), 32'h7);
        run(3);

        // Bypass on the LSB-first instance: 0x80 offered exactly on the last-bit edge.
        dat[1] = 32'h01; vld[1] = 1'b1;
        sent = 1'b0; cap = '0; nb = 0;
        repeat (22) begin
            step();
            if (av[1]) begin
                cap = {cap[14:0], a[1]};
                nb++;
            end
            if (!sent && mcnt[1] == 1 && midx[1] == 7) begin
                check("bypass_ready", 32'(rdy[1]), 32'd1);
                dat[1] = 32'h80; vld[1] = 1'b1; sent = 1'b1;
            end
        end
        check("bypass_seq", 32'(cap), 32'h8001);
        check("bypass_nbits", 32'(nb), 32'd16);

        // 10-bit downstream pattern 01_0011_0111.
        dat[2] = 32'h137; vld[2] = 1'b1;
        cap = '0; nb = 0;
        repeat (14) begin
            step();
            if (av[2]) begin
                cap = {cap[14:0], a[2]};
                nb++;
            end
        end
        check("w10_seq", 32'(cap[9:0]), 32'h137);
        check("w10_nbits", 32'(nb), 32'd10);

        // Reset mid-word: nothing stale after release.
        dat[0] = 32'hFF; vld[0] = 1'b1;
        run(4);
        do_reset();
        vld = '0;
        nb = 0;
        repeat (12) begin
            step();
            if (av[0]) nb++;
        end
        check("rst_no_stale", 32'(nb), 32'd0);

        // Randomized traffic with occasional stalls and resets.
        repeat (3000) begin
            en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && ($urandom_range(0, 2) == 0)) begin
                    vld[i] = 1'b1;
                    dat[i] = $urandom & ((32'h1 << wd[i]) - 32'h1);
                end
            end
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
